// File: rtl/ntt_ctrl.sv
// ntt_ctrl: address/strobe sequencer for an in-place radix-2 NTT/INTT.
// Each stage reads N/2 butterfly operand pairs. It then drains for LAT cycles,
// so that every stage's write-backs land before the next stage reads.
module ntt_ctrl #(
  parameter int LOGN    = 8,
  parameter int MEM_LAT = 1,
  parameter int BU_LAT  = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            mode_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            rd_en_o,
  output logic [LOGN-1:0] rd_addr_u_o,
  output logic [LOGN-1:0] rd_addr_t_o,
  output logic [LOGN-1:0] tw_addr_o,
  output logic            CT_nGS_o,
  output logic            wr_en_o,
  output logic [LOGN-1:0] wr_addr_u_o,
  output logic [LOGN-1:0] wr_addr_t_o
);

  localparam int LAT = MEM_LAT + BU_LAT;
  localparam int PW  = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [LOGN-2:0] C_J_LAST     = {(LOGN-1){1'b1}};
  localparam logic [PW-1:0]   C_P_LAST     = PW'(LOGN - 1);
  localparam logic [CW-1:0]   C_DRAIN_LAST = CW'(LAT - 1);
  localparam logic [LOGN:0]   C_LOGN       = (LOGN+1)'(LOGN);
  localparam logic [LOGN:0]   C_ONE        = (LOGN+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_p;
  logic [LOGN-2:0] r_j;
  logic [CW-1:0]   r_cnt;
  logic            r_mode;
  logic            r_busy;
  logic            r_done;
  logic            r_rd_en;
  logic [LOGN-1:0] r_rd_u;
  logic [LOGN-1:0] r_rd_t;
  logic [LOGN-1:0] r_tw;

  logic            r_pv [LAT];
  logic [LOGN-1:0] r_pu [LAT];
  logic [LOGN-1:0] r_pt [LAT];

  logic [3*LOGN-1:0] w_addr_next;
  logic [3*LOGN-1:0] w_addr_first;
  logic [LOGN-2:0]   w_j_inc;
  logic [PW-1:0]     w_p_inc;

  // Butterfly addressing for stage p, index j. Forward (CT) walks the half-size
  // from N/2 down to 1, and inverse (GS) walks it from 1 up to N/2.
  // Packed as {u, t, tw}.
  function automatic logic [3*LOGN-1:0] f_addr(input logic            mode,
                                               input logic [PW-1:0]   p,
                                               input logic [LOGN-2:0] j);
    logic [LOGN:0] jj;
    logic [LOGN:0] pp;
    logic [LOGN:0] s;
    logic [LOGN:0] len;
    logic [LOGN:0] g;
    logic [LOGN:0] u;
    logic [LOGN:0] t;
    logic [LOGN:0] tw;
    jj = {2'b00, j};
    pp = {{(LOGN+1-PW){1'b0}}, p};
    if (mode) begin
      s = C_LOGN - C_ONE - pp;
    end else begin
      s = pp;
    end
    len = C_ONE << s;
    g   = jj >> s;
    u   = (g << (s + C_ONE)) | (jj & (len - C_ONE));
    t   = u + len;
    if (mode) begin
      tw = (C_ONE << pp) + g;
    end else begin
      tw = (C_ONE << (C_LOGN - pp)) - C_ONE - g;
    end
    return {u[LOGN-1:0], t[LOGN-1:0], tw[LOGN-1:0]};
  endfunction

  assign w_j_inc      = r_j + {{(LOGN-2){1'b0}}, 1'b1};
  assign w_p_inc      = r_p + {{(PW-1){1'b0}}, 1'b1};
  assign w_addr_next  = f_addr(r_mode, r_p, w_j_inc);
  assign w_addr_first = (r_state == S_IDLE) ? f_addr(mode_i, {PW{1'b0}}, {(LOGN-1){1'b0}})
                                            : f_addr(r_mode, w_p_inc, {(LOGN-1){1'b0}});

  // Sequencer FSM: issues one butterfly per RUN cycle and inserts a LAT-cycle
  // drain between stages. Every output is registered.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_p     <= {PW{1'b0}};
      r_j     <= {(LOGN-1){1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_rd_u  <= {LOGN{1'b0}};
      r_rd_t  <= {LOGN{1'b0}};
      r_tw    <= {LOGN{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_state <= S_RUN;
            r_p     <= {PW{1'b0}};
            r_j     <= {(LOGN-1){1'b0}};
            r_mode  <= mode_i;
            r_busy  <= 1'b1;
            r_rd_en <= 1'b1;
            {r_rd_u, r_rd_t, r_tw} <= w_addr_first;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (r_j == C_J_LAST) begin
            r_state <= S_DRAIN;
            r_cnt   <= {CW{1'b0}};
            r_rd_en <= 1'b0;
            r_rd_u  <= {LOGN{1'b0}};
            r_rd_t  <= {LOGN{1'b0}};
            r_tw    <= {LOGN{1'b0}};
          end else begin
            r_j     <= w_j_inc;
            r_rd_en <= 1'b1;
            {r_rd_u, r_rd_t, r_tw} <= w_addr_next;
          end
        end
        S_DRAIN: begin
          if (r_cnt == C_DRAIN_LAST) begin
            if (r_p == C_P_LAST) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_p     <= w_p_inc;
              r_j     <= {(LOGN-1){1'b0}};
              r_rd_en <= 1'b1;
              {r_rd_u, r_rd_t, r_tw} <= w_addr_first;
            end
          end else begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_rd_en <= 1'b0;
        end
      endcase
    end
  end

  // Write-back delay line: read strobe/addresses re-emerge LAT cycles later
  // as the write strobe/addresses. Reset drops every in-flight tag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pu[i] <= {LOGN{1'b0}};
        r_pt[i] <= {LOGN{1'b0}};
      end
    end else begin
      r_pv[0] <= r_rd_en;
      r_pu[0] <= r_rd_u;
      r_pt[0] <= r_rd_t;
      for (int i = 1; i < LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pu[i] <= r_pu[i-1];
        r_pt[i] <= r_pt[i-1];
      end
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign rd_en_o     = r_rd_en;
  assign rd_addr_u_o = r_rd_u;
  assign rd_addr_t_o = r_rd_t;
  assign tw_addr_o   = r_tw;
  assign CT_nGS_o    = r_mode;
  assign wr_en_o     = r_pv[LAT-1];
  assign wr_addr_u_o = r_pu[LAT-1];
  assign wr_addr_t_o = r_pt[LAT-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl with default parameters (N=256, LAT=3).
// Cycle 0 is the cycle in which start_i is high.
module tb_ntt_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       start_i;
  logic       mode_i;
  logic       busy_o;
  logic       done_o;
  logic       rd_en_o;
  logic [7:0] rd_addr_u_o;
  logic [7:0] rd_addr_t_o;
  logic [7:0] tw_addr_o;
  logic       CT_nGS_o;
  logic       wr_en_o;
  logic [7:0] wr_addr_u_o;
  logic [7:0] wr_addr_t_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wr_cnt, rd_cnt, done_cnt, done_cyc, ct_bad;
  logic exp_ct;

  ntt_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
    .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o),
    .rd_addr_u_o(rd_addr_u_o), .rd_addr_t_o(rd_addr_t_o), .tw_addr_o(tw_addr_o),
    .CT_nGS_o(CT_nGS_o), .wr_en_o(wr_en_o),
    .wr_addr_u_o(wr_addr_u_o), .wr_addr_t_o(wr_addr_t_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge and keep statistics.
  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
    if (wr_en_o === 1'b1) wr_cnt++;
    if (rd_en_o === 1'b1) rd_cnt++;
    if (done_o === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy_o === 1'b1 && CT_nGS_o !== exp_ct) ct_bad++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // Pulse start in the current cycle, which becomes cycle 0.
  task automatic start_run(input logic m);
    start_i = 1'b1;
    mode_i  = m;
    exp_ct  = m;
    cyc = 0; wr_cnt = 0; rd_cnt = 0; done_cnt = 0; done_cyc = -1; ct_bad = 0;
    step();
    start_i = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input int u, input int t, input int tw);
    chk({tag, "_rd_en"}, 32'(rd_en_o), 32'd1);
    chk({tag, "_u"}, 32'(rd_addr_u_o), 32'(u));
    chk({tag, "_t"}, 32'(rd_addr_t_o), 32'(t));
    chk({tag, "_tw"}, 32'(tw_addr_o), 32'(tw));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {18'd0, busy_o, done_o, rd_en_o, CT_nGS_o, wr_en_o, tw_addr_o[0],
              rd_addr_u_o | rd_addr_t_o | tw_addr_o | wr_addr_u_o | wr_addr_t_o}, 32'd0);
  endtask

  initial begin
    int gap;
    rst_ni = 1'b0; start_i = 1'b0; mode_i = 1'b0; exp_ct = 1'b0;
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; done_cyc = -1; ct_bad = 0;
    repeat (3) step();
    chk_all_zero("reset_outputs");
    rst_ni = 1'b1;
    step();
    chk("idle_busy", 32'(busy_o), 32'd0);

    // Forward transform.
    start_run(1'b1);
    chk_rd("fwd_c1", 0, 128, 1);
    chk("fwd_c1_busy", 32'(busy_o), 32'd1);
    chk("fwd_c1_ct", 32'(CT_nGS_o), 32'd1);
    step();
    chk_rd("fwd_c2", 1, 129, 1);
    step();
    chk("fwd_c3_wr_en", 32'(wr_en_o), 32'd0);
    step();
    chk("fwd_c4_wr_en", 32'(wr_en_o), 32'd1);
    chk("fwd_c4_wr_u", 32'(wr_addr_u_o), 32'd0);
    chk("fwd_c4_wr_t", 32'(wr_addr_t_o), 32'd128);
    run_to(128);
    chk_rd("fwd_s0_last", 127, 255, 1);
    gap = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (rd_en_o === 1'b0) gap++;
      chk("drain_tw_zero", 32'(tw_addr_o), 32'd0);
    end
    chk("drain_gap", 32'(gap), 32'd3);
    chk("drain_busy", 32'(busy_o), 32'd1);
    chk("s0_last_wr_en", 32'(wr_en_o), 32'd1);
    chk("s0_last_wr_u", 32'(wr_addr_u_o), 32'd127);
    chk("s0_last_wr_t", 32'(wr_addr_t_o), 32'd255);
    step();
    chk_rd("fwd_s1_first", 0, 64, 2);
    chk("s1_first_no_wr", 32'(wr_en_o), 32'd0);
    // Opposite-mode start in the middle of the run must be ignored.
    run_to(500);
    start_i = 1'b1; mode_i = 1'b0;
    step();
    start_i = 1'b0;
    run_to(918);
    chk_rd("fwd_s7_first", 0, 1, 128);
    run_to(1045);
    chk_rd("fwd_s7_last", 254, 255, 255);
    run_to(1048);
    chk("fwd_c1048_busy", 32'(busy_o), 32'd1);
    chk("fwd_c1048_done", 32'(done_o), 32'd0);
    step();
    chk("fwd_c1049_done", 32'(done_o), 32'd1);
    chk("fwd_c1049_busy", 32'(busy_o), 32'd0);
    run_to(1052);
    chk("fwd_done_cnt", 32'(done_cnt), 32'd1);
    chk("fwd_done_cyc", 32'(done_cyc), 32'd1049);
    chk("fwd_wr_cnt", 32'(wr_cnt), 32'd1024);
    chk("fwd_rd_cnt", 32'(rd_cnt), 32'd1024);
    chk("fwd_ct_const", 32'(ct_bad), 32'd0);
    chk("fwd_ct_hold", 32'(CT_nGS_o), 32'd1);

    // Inverse transform.
    start_run(1'b0);
    chk_rd("inv_s0_j0", 0, 1, 255);
    chk("inv_c1_ct", 32'(CT_nGS_o), 32'd0);
    run_to(128);
    chk_rd("inv_s0_j127", 254, 255, 128);
    run_to(918);
    chk_rd("inv_s7_j0", 0, 128, 1);
    run_to(1052);
    chk("inv_done_cyc", 32'(done_cyc), 32'd1049);
    chk("inv_done_cnt", 32'(done_cnt), 32'd1);
    chk("inv_wr_cnt", 32'(wr_cnt), 32'd1024);
    chk("inv_ct_const", 32'(ct_bad), 32'd0);

    // Mid-operation reset.
    start_run(1'b1);
    run_to(500);
    chk("pre_reset_busy", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    step();
    chk_all_zero("mid_reset_outputs");
    rst_ni = 1'b1;
    step();
    chk("post_reset_wr_en", 32'(wr_en_o), 32'd0);
    chk("post_reset_busy", 32'(busy_o), 32'd0);
    start_run(1'b1);
    chk_rd("restart_c1", 0, 128, 1);
    chk("restart_wr_c1", 32'(wr_en_o), 32'd0);
    step();
    step();
    chk("restart_wr_c3", 32'(wr_cnt), 32'd0);
    run_to(1052);
    chk("restart_done_cyc", 32'(done_cyc), 32'd1049);
    chk("restart_wr_cnt", 32'(wr_cnt), 32'd1024);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_ctrl.md
NTT_CTRL -- requirements
Module: ntt_ctrl

Interface
REQ-001 SHALL have parameter LOGN, default 8, meaning log2 of the transform size; N = 2^LOGN coefficients.
REQ-002 SHALL have parameter MEM_LAT, default 1, meaning the coefficient RAM and twiddle ROM read latency in cycles.
REQ-003 SHALL have parameter BU_LAT, default 2, meaning the butterfly unit latency from input to registered output; LAT = MEM_LAT + BU_LAT.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, synchronous active-low reset.
REQ-006 SHALL have port start_i, input, 1, single-cycle request to run one transform.
REQ-007 SHALL have port mode_i, input, 1: 1 = forward NTT (CT), 0 = inverse (GS); sampled with start_i.
REQ-008 SHALL have port busy_o, output, 1, high while a transform is in progress.
REQ-009 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port rd_en_o, output, 1, coefficient and twiddle read strobe.
REQ-011 SHALL have ports rd_addr_u_o and rd_addr_t_o, output, LOGN each, butterfly operand read addresses.
REQ-012 SHALL have port tw_addr_o, output, LOGN, twiddle ROM address, issued in the same cycle as the operand reads.
REQ-013 SHALL have port CT_nGS_o, output, 1, butterfly mode select, equal to the latched mode.
REQ-014 SHALL have port wr_en_o, output, 1, write strobe for the butterfly results.
REQ-015 SHALL have ports wr_addr_u_o and wr_addr_t_o, output, LOGN each, write-back addresses.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-017 SHALL leave IDLE for RUN on start_i=1, clearing stage p=0 and butterfly index j=0 and latching mode_i; start_i SHALL be ignored in every other state.
REQ-018 SHALL, in RUN, assert rd_en_o every cycle and increment j; on j = N/2-1 it SHALL go to DRAIN.
REQ-019 SHALL hold DRAIN for exactly LAT cycles, then go to RUN with p+1 and j=0, or to DONE when p = LOGN-1.
REQ-020 SHALL hold DONE for one cycle with done_o=1, then return to IDLE.
REQ-021 SHALL drive busy_o=1 in RUN and DRAIN only.
REQ-022 SHALL compute addresses in the forward mode as: len = 2^(LOGN-1-p), s = log2(len), g = j>>s, u = (g<<(s+1)) | (j & (len-1)), t = u + len, tw = 2^p + g.
REQ-023 SHALL compute addresses in the inverse mode as: len = 2^p, s = p, same u, t and g formulas, tw = 2^(LOGN-p) - 1 - g.
REQ-024 SHALL drive wr_en_o, wr_addr_u_o and wr_addr_t_o as rd_en_o, rd_addr_u_o and rd_addr_t_o delayed by exactly LAT cycles through a valid-tagged shift pipeline.
REQ-025 SHALL ensure the DRAIN length makes the last write of stage p occur in the cycle before the first read of stage p+1 (no read-after-write hazard).
REQ-026 SHALL hold the read addresses and tw_addr_o at 0 and rd_en_o at 0 whenever the state is not RUN.
REQ-027 SHALL hold CT_nGS_o constant from the start cycle until the next accepted start.
REQ-028 SHALL, with defaults (LAT=3), take 8 x (128+3) = 1048 cycles of RUN/DRAIN per transform, with done_o high in the 1049th cycle after the start cycle.

Reset
REQ-029 SHALL, on rst_ni=0 at a clock edge, go to IDLE and clear p, j, the latched mode and all delay-pipeline valid bits.
REQ-030 SHALL drive every output to 0 during reset.
REQ-031 SHALL generate no wr_en_o pulse for reads issued before a mid-operation reset.
REQ-032 SHALL accept a start_i in the first cycle after rst_ni returns high.

Verification
REQ-033 Forward, start at cycle 0 -> cycle 1: rd_en_o=1, u=0, t=128, tw=1; cycle 2: u=1, t=129, tw=1; cycle 4: wr_en_o=1, wr_addr_u_o=0, wr_addr_t_o=128.
REQ-034 Forward, last stage -> first issue u=0, t=1, tw=128; last issue u=254, t=255, tw=255; done_o=1 at cycle 1049 only.
REQ-035 Inverse -> stage 0: j=0 gives u=0, t=1, tw=255 and j=127 gives u=254, t=255, tw=128; stage 7: j=0 gives u=0, t=128, tw=1; CT_nGS_o=0 throughout.
REQ-036 Stage boundary -> rd_en_o=0 for exactly 3 cycles; the last wr_en_o of the stage occurs in the cycle before the next rd_en_o.
REQ-037 start_i pulsed mid-run with the opposite mode_i -> ignored; the cycle count and CT_nGS_o are unchanged.
REQ-038 rst_ni=0 for one cycle at cycle 500 -> all outputs 0, no wr_en_o afterwards, busy_o=0; a new start_i at cycle 502 runs a full 1048-cycle transform.
